fifo_rd_stream: RTL and testbench

Read-side consumer for the asynchronous FIFO memory, living entirely in the read clock domain. It issues read enables against the FIFO's synchronized `empty` flag and absorbs the memory's one-cycle registered read latency. It delivers words in order on a valid/ready output stream through a small internal buffer, sustaining one word per cycle without a combinational path from `out_ready` to `r_en`. It also counts delivered words and latches memory read errors.

---
 rtl/fifo_rd_pkg.sv | 9 +
 rtl/rd_stream_buf.sv | 57 +++++
 rtl/fifo_rd_stream.sv | 86 ++++++++
 tb/tb_fifo_rd_stream.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared FSM encoding and default widths for the FIFO read-side streamer
//   rd_state_e      : IDLE / RUN / STOP
//   FIFO_DATA_WIDTH : default word width, matches the FIFO memory
//   RD_CNT_WIDTH    : default delivered-word counter width
package fifo_rd_pkg;
    typedef enum logic [1:0] {IDLE, RUN, STOP} rd_state_e;
    localparam int FIFO_DATA_WIDTH = 8;
    localparam int RD_CNT_WIDTH = 32;
endpackage

// File: rtl/rd_stream_buf.sv
// rd_stream_buf: circular output buffer between the FIFO memory read port and the stream
//   clk, rst  : clock, synchronous active-high reset
//   push      : capture push_data at the tail (never asserted while full)
//   pop       : release the head entry
//   occ       : number of stored entries, 0..DEPTH
//   head_data : oldest stored entry (0 after reset)
module rd_stream_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [OW-1:0]         occ,
    output logic [DATA_WIDTH-1:0] head_data
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [OW-1:0] occ_q, occ_d;

    // pointers wrap explicitly so non-power-of-two depths work
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[tail_q] = push_data;
        head_d = pop ? wrap_inc(head_q) : head_q;
        tail_d = push ? wrap_inc(tail_q) : tail_q;
        occ_d = occ_q + OW'(push) - OW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            head_q <= '0;
            tail_q <= '0;
            occ_q <= '0;
        end else begin
            mem_q <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;
    assign head_data = mem_q[head_q];
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-domain consumer that drains the async FIFO memory onto a valid/ready stream
//   r_clk, r_rst         : read clock, synchronous active-high reset
//   rd_enable            : permission to drain the FIFO
//   empty                : FIFO empty flag, already synchronized to r_clk
//   rd_data, read_error  : FIFO memory data_out (one-cycle registered latency) and error flag
//   r_en                 : read enable to the FIFO memory
//   out_valid, out_data, out_ready : output stream
//   busy                 : FSM not idle
//   rd_count             : words accepted downstream (wraps)
//   err_sticky           : read_error seen since reset
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int BUF_DEPTH = 4,
    parameter int CNT_WIDTH = RD_CNT_WIDTH
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  rd_enable,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  read_error,
    output logic                  r_en,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  err_sticky
);
    localparam int OW = $clog2(BUF_DEPTH + 1);

    rd_state_e state_q, state_d;
    logic inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
    logic err_q, err_d;
    logic [OW-1:0] occ;
    logic pop;

    assign out_valid = (occ != '0);
    assign pop = out_valid && out_ready;

    always_comb begin
        // STOP lingers only while the last issued read is still on its way back
        state_d = rd_enable ? RUN
                : (state_q == RUN) ? STOP
                : (state_q == STOP && inflight_q) ? STOP : IDLE;
        // counting the in-flight word reserves its slot, so a read never lands on a full buffer
        r_en = (state_q == RUN) && !empty && ((occ + OW'(inflight_q)) < OW'(BUF_DEPTH));
        inflight_d = r_en;
        rd_count_d = rd_count_q + CNT_WIDTH'(pop);
        err_d = err_q | read_error;
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state_q <= IDLE;
            inflight_q <= 1'b0;
            rd_count_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            inflight_q <= inflight_d;
            rd_count_q <= rd_count_d;
            err_q <= err_d;
        end
    end

    rd_stream_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk(r_clk),
        .rst(r_rst),
        .push(inflight_q),
        .push_data(rd_data),
        .pop(pop),
        .occ(occ),
        .head_data(out_data)
    );

    assign busy = (state_q != IDLE);
    assign rd_count = rd_count_q;
    assign err_sticky = err_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed and randomized bench with a queue-based FIFO/stream reference model
module tb_fifo_rd_stream;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int CW = 32;
  logic r_clk = 1'b0;
  logic r_rst = 1'b1;
  logic rd_enable = 1'b0;
  logic empty = 1'b1;
  logic [DW-1:0] rd_data = '0;
  logic read_error = 1'b0;
  logic out_ready = 1'b0;
  logic r_en, out_valid, busy, err_sticky;
  logic [DW-1:0] out_data;
  logic [CW-1:0] rd_count;
  fifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH), .CNT_WIDTH(CW)) u_dut (
    .r_clk(r_clk),
    .r_rst(r_rst),
    .rd_enable(rd_enable),
    .empty(empty),
    .rd_data(rd_data),
    .read_error(read_error),
    .r_en(r_en),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .busy(busy),
    .rd_count(rd_count),
    .err_sticky(err_sticky)
  );
  always #5 r_clk = ~r_clk;
  logic [DW-1:0] fifo[$];
  logic [DW-1:0] exp_q[$];
  bit pend, en_prev, busy_m, err_m, chk_on;
  logic [CW-1:0] cnt_m = '0;
  int checks = 0;
  int errors = 0;
  int reads = 0;
  int delivered = 0;
  int n;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask
  task automatic load(input logic [DW-1:0] w);
    fifo.push_back(w);
    empty = 1'b0;
  endtask
  task automatic step();
    bit ren, hs, rs, es, ei;
    @(negedge r_clk);
    if (chk_on) begin
      chk("r_en", r_en, en_prev && !empty && (exp_q.size() < DEPTH));
      chk("r_en_while_empty", r_en && empty, 1'b0);
      chk("push_into_full", r_en && (exp_q.size() >= DEPTH), 1'b0);
      chk("out_valid", out_valid, exp_q.size() > int'(pend));
      if (exp_q.size() > int'(pend)) chk("out_data", out_data, exp_q[0]);
      chk("busy", busy, busy_m);
      chk("rd_count", rd_count, cnt_m);
      chk("err_sticky", err_sticky, err_m);
    end
    ren = r_en;
    hs = out_valid && out_ready;
    rs = r_rst;
    es = rd_enable;
    ei = read_error;
    @(posedge r_clk);
    #1;
    if (rs) begin
      exp_q.delete();
      pend = 0;
      en_prev = 0;
      busy_m = 0;
      err_m = 0;
      cnt_m = '0;
      if (ren) rd_data = 8'hEE;
    end else begin
      if (hs && exp_q.size() > int'(pend)) begin
        void'(exp_q.pop_front());
        cnt_m++;
        delivered++;
      end
      busy_m = es || en_prev || (busy_m && pend);
      pend = ren && (fifo.size() != 0);
      if (ren) reads++;
      if (pend) begin
        rd_data = fifo.pop_front();
        exp_q.push_back(rd_data);
      end
      empty = (fifo.size() == 0);
      err_m = err_m | ei;
      en_prev = es;
    end
  endtask
  task automatic check_reset();
    #2;
    chk("rst_r_en", r_en, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_count", rd_count, 32'd0);
    chk("rst_err_sticky", err_sticky, 1'b0);
  endtask
  initial begin
    chk_on = 0;
    r_rst = 1;
    step();
    step();
    r_rst = 0;
    chk_on = 1;
    check_reset();
    load(8'h11);
    load(8'h22);
    load(8'h33);
    out_ready = 1;
    rd_enable = 1;
    repeat (3) step();
    #2;
    chk("first_valid_cycle3", out_valid, 1'b1);
    chk("first_word", out_data, 8'h11);
    repeat (6) step();
    chk("drain_count", rd_count, 32'd3);
    rd_enable = 0;
    repeat (4) step();
    out_ready = 0;
    reads = 0;
    for (int i = 0; i < 10; i++) load(DW'(8'h40 + i));
    rd_enable = 1;
    repeat (10) step();
    chk("bp_reads", reads, 4);
    chk("bp_valid", out_valid, 1'b1);
    out_ready = 1;
    delivered = 0;
    repeat (20) step();
    chk("bp_delivered", delivered, 10);
    chk("bp_count", rd_count, 32'd13);
    rd_enable = 0;
    repeat (4) step();
    for (int i = 0; i < 5; i++) load(DW'(8'h60 + i));
    delivered = 0;
    rd_enable = 1;
    n = 0;
    while (r_en !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("stop_r_en_seen", r_en, 1'b1);
    rd_enable = 0;
    repeat (4) step();
    chk("stop_delivered", delivered, 1);
    chk("stop_busy", busy, 1'b0);
    chk("stop_r_en", r_en, 1'b0);
    fifo.delete();
    empty = 1;
    delivered = 0;
    rd_enable = 1;
    out_ready = 1;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) load(DW'(8'h80 + i));
      step();
    end
    repeat (5) step();
    chk("tog_delivered", delivered, 10);
    read_error = 1;
    step();
    read_error = 0;
    repeat (5) step();
    chk("err_latched", err_sticky, 1'b1);
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) load(DW'($urandom));
      if ($urandom_range(0, 19) == 0) rd_enable = ~rd_enable;
      if ($urandom_range(0, 99) == 0) read_error = 1;
      step();
      read_error = 0;
    end
    rd_enable = 1;
    out_ready = 1;
    n = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0) && n < 1000) begin
      step();
      n++;
    end
    chk("rand_drain_in_time", n < 1000, 1'b1);
    rd_enable = 0;
    repeat (4) step();
    chk("rand_drained_valid", out_valid, 1'b0);
    chk("rand_idle_busy", busy, 1'b0);
    out_ready = 0;
    for (int i = 0; i < 6; i++) load(DW'(8'hA0 + i));
    rd_enable = 1;
    n = 0;
    while (!(exp_q.size() == 3 && pend) && n < 20) begin
      step();
      n++;
    end
    chk("rst_setup_valid", out_valid, 1'b1);
    chk("rst_setup_in_time", n < 20, 1'b1);
    r_rst = 1;
    step();
    r_rst = 0;
    rd_enable = 0;
    fifo.delete();
    empty = 1;
    check_reset();
    repeat (3) step();
    chk("rst_no_capture", out_valid, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
